// File: rtl/and_gate_pkg.sv
// and_gate_pkg
// Shared constants and helpers for the and_gate block.
//   CNT_W_DEFAULT : default width of the statistics counters
//   sat_max()     : all-ones value of a w-bit counter (its saturation point)
package and_gate_pkg;

    localparam int CNT_W_DEFAULT = 16;

    // A 64-bit return keeps the shift well defined for widths up to 32.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/and_gate_sat_cnt.sv
// and_gate_sat_cnt
// CNT_W-wide up counter that sticks at its all-ones value instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : add one on this edge (ignored once saturated)
//   clr   : synchronous clear, takes priority over inc
//   cnt   : current count
module and_gate_sat_cnt
    import and_gate_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/and_gate.sv
// and_gate
// Two-input AND with a registered copy, a rising-edge pulse and optional
// saturating statistics counters.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (release synchronised internally)
//   X, Y     : AND operands
//   clr      : synchronous clear of the statistics counters
//   F        : combinational X & Y
//   F_q      : F registered
//   f_rise   : one-cycle pulse the cycle after F_q goes 0->1
//   hi_cnt   : saturating count of edges that sampled F=1
//   rise_cnt : saturating count of f_rise pulses
// Build option: define AND_GATE_STATS_EN to build the counters and clr;
// otherwise hi_cnt/rise_cnt are tied to zero and clr is ignored.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             X,
    input  logic             Y,
    input  logic             clr,
    output logic             F,
    output logic             F_q,
    output logic             f_rise,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [CNT_W-1:0] rise_cnt
);

    logic [1:0] rst_sync;
    logic       run;
    logic       f_q_p1;

    // Purely combinational so F follows the operands even while in reset.
    assign F = X & Y;

    // Reset asserts immediately; release walks through two flops so that
    // registered logic starts on the third edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Stage p0: F_q captures F. Stage p1: delayed F_q for edge detect.
    // Stage p2: f_rise. f_q_p1 follows F_q every cycle, so f_rise can
    // never stay high for two cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F_q    <= 1'b0;
            f_q_p1 <= 1'b0;
            f_rise <= 1'b0;
        end else if (!run) begin
            F_q    <= 1'b0;
            f_q_p1 <= 1'b0;
            f_rise <= 1'b0;
        end else begin
            F_q    <= F;
            f_q_p1 <= F_q;
            f_rise <= F_q & ~f_q_p1;
        end
    end

`ifdef AND_GATE_STATS_EN
    // Counters are held clear until the reset release has propagated.
    and_gate_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_hi_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (run & F),
        .clr   (clr | ~run),
        .cnt   (hi_cnt)
    );

    and_gate_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_rise_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (run & f_rise),
        .clr   (clr | ~run),
        .cnt   (rise_cnt)
    );
`else
    logic unused_clr;

    assign hi_cnt     = '0;
    assign rise_cnt   = '0;
    assign unused_clr = clr;
`endif

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;

    localparam int CNT_W = 4;
`ifdef AND_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clk_en = 1'b0;
    logic             rst_n = 1'b1;
    logic             X = 1'b0;
    logic             Y = 1'b0;
    logic             clr = 1'b0;
    logic             F;
    logic             F_q;
    logic             f_rise;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] rise_cnt;

    int total = 0;
    int bad   = 0;

    and_gate #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .X        (X),
        .Y        (Y),
        .clr      (clr),
        .F        (F),
        .F_q      (F_q),
        .f_rise   (f_rise),
        .hi_cnt   (hi_cnt),
        .rise_cnt (rise_cnt)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // No clock: truth table plus X/Z operands against a 0.
    task automatic test_comb();
        logic [1:0] vec [4];
        logic       exp_f [4];
        vec   = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp_f = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            {X, Y} = vec[i];
            #10;
            total++;
            if (F !== exp_f[i]) begin bad++; $display("FAIL comb_%0d got=%b want=%b", i, F, exp_f[i]); end
        end
        X = 1'bx; Y = 1'b0; #10;
        total++;
        if (F !== 1'b0) begin bad++; $display("FAIL comb_x0 got=%b want=0", F); end
        X = 1'b0; Y = 1'bz; #10;
        total++;
        if (F !== 1'b0) begin bad++; $display("FAIL comb_0z got=%b want=0", F); end
    endtask

    // Asynchronous reset with no clock running.
    task automatic test_reset();
        X = 1'b1; Y = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (F !== 1'b1) begin bad++; $display("FAIL rst_F got=%b want=1", F); end
        total++;
        if (F_q !== 1'b0) begin bad++; $display("FAIL rst_F_q got=%b want=0", F_q); end
        total++;
        if (f_rise !== 1'b0) begin bad++; $display("FAIL rst_f_rise got=%b want=0", f_rise); end
        total++;
        if (hi_cnt !== 4'd0) begin bad++; $display("FAIL rst_hi_cnt got=%0d want=0", hi_cnt); end
        total++;
        if (rise_cnt !== 4'd0) begin bad++; $display("FAIL rst_rise_cnt got=%0d want=0", rise_cnt); end
    endtask

    // Release, sync out, then X=Y=1 for five edges.
    task automatic test_basic();
        int pulses = 0;
        X = 1'b0; Y = 1'b0;
        clk_en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        total++;
        if (F_q !== 1'b0) begin bad++; $display("FAIL basic_idle_F_q got=%b want=0", F_q); end
        X = 1'b1; Y = 1'b1;
        tick();
        total++;
        if (F_q !== 1'b1) begin bad++; $display("FAIL basic_F_q_lat got=%b want=1", F_q); end
        total++;
        if (f_rise !== 1'b0) begin bad++; $display("FAIL basic_rise_early got=%b want=0", f_rise); end
        for (int i = 1; i < 5; i++) begin
            tick();
            if (i == 1) begin
                total++;
                if (f_rise !== 1'b1) begin bad++; $display("FAIL basic_rise_pulse got=%b want=1", f_rise); end
            end
            if (f_rise === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL basic_pulses got=%0d want=1", pulses); end
        total++;
        if (hi_cnt !== (STATS ? 4'd5 : 4'd0)) begin bad++; $display("FAIL basic_hi_cnt got=%0d want=%0d", hi_cnt, STATS ? 5 : 0); end
        total++;
        if (rise_cnt !== (STATS ? 4'd1 : 4'd0)) begin bad++; $display("FAIL basic_rise_cnt got=%0d want=%0d", rise_cnt, STATS ? 1 : 0); end
    endtask

    // clr on an edge that samples F=1: clear wins, F_q untouched.
    task automatic test_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (hi_cnt !== 4'd0) begin bad++; $display("FAIL clr_hi_cnt got=%0d want=0", hi_cnt); end
        total++;
        if (rise_cnt !== 4'd0) begin bad++; $display("FAIL clr_rise_cnt got=%0d want=0", rise_cnt); end
        total++;
        if (F_q !== 1'b1) begin bad++; $display("FAIL clr_F_q got=%b want=1", F_q); end
    endtask

    // 20 edges of F=1 on a 4-bit counter.
    task automatic test_sat();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) begin
                total++;
                if (hi_cnt !== (STATS ? 4'd14 : 4'd0)) begin bad++; $display("FAIL sat_hi_14 got=%0d want=%0d", hi_cnt, STATS ? 14 : 0); end
            end
        end
        total++;
        if (hi_cnt !== (STATS ? 4'd15 : 4'd0)) begin bad++; $display("FAIL sat_hi_cnt got=%0d want=%0d", hi_cnt, STATS ? 15 : 0); end
        total++;
        if (rise_cnt !== 4'd0) begin bad++; $display("FAIL sat_rise_cnt got=%0d want=0", rise_cnt); end
    endtask

    // Y=1, X toggled 1,1,0,0 three times: three rises, six high samples.
    task automatic test_toggle();
        int pulses = 0;
        int consec = 0;
        logic prev = 1'b0;
        X = 1'b0;
        tick(); tick(); tick();
        total++;
        if (F_q !== 1'b0) begin bad++; $display("FAIL tog_idle_F_q got=%b want=0", F_q); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                X = (j < 2);
                tick();
                if (f_rise === 1'b1) pulses++;
                if (f_rise === 1'b1 && prev === 1'b1) consec++;
                prev = f_rise;
            end
        end
        total++;
        if (pulses != 3) begin bad++; $display("FAIL tog_pulses got=%0d want=3", pulses); end
        total++;
        if (consec != 0) begin bad++; $display("FAIL tog_consec got=%0d want=0", consec); end
        total++;
        if (hi_cnt !== (STATS ? 4'd6 : 4'd0)) begin bad++; $display("FAIL tog_hi_cnt got=%0d want=%0d", hi_cnt, STATS ? 6 : 0); end
        total++;
        if (rise_cnt !== (STATS ? 4'd3 : 4'd0)) begin bad++; $display("FAIL tog_rise_cnt got=%0d want=%0d", rise_cnt, STATS ? 3 : 0); end
    endtask

    // Reset mid-run, release with F already high.
    task automatic test_mid_reset();
        int pulses = 0;
        X = 1'b1; Y = 1'b1;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (F_q !== 1'b0) begin bad++; $display("FAIL mid_F_q got=%b want=0", F_q); end
        total++;
        if (hi_cnt !== 4'd0) begin bad++; $display("FAIL mid_hi_cnt got=%0d want=0", hi_cnt); end
        total++;
        if (F !== 1'b1) begin bad++; $display("FAIL mid_F got=%b want=1", F); end
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 2) begin
                total++;
                if (F_q !== 1'b0) begin bad++; $display("FAIL mid_sync_F_q got=%b want=0", F_q); end
            end
            if (i == 3) begin
                total++;
                if (F_q !== 1'b1) begin bad++; $display("FAIL mid_first_F_q got=%b want=1", F_q); end
            end
            if (f_rise === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL mid_pulses got=%0d want=1", pulses); end
        total++;
        if (hi_cnt !== (STATS ? 4'd9 : 4'd0)) begin bad++; $display("FAIL mid_hi_cnt got=%0d want=%0d", hi_cnt, STATS ? 9 : 0); end
        total++;
        if (rise_cnt !== (STATS ? 4'd1 : 4'd0)) begin bad++; $display("FAIL mid_rise_cnt got=%0d want=%0d", rise_cnt, STATS ? 1 : 0); end
    endtask

    initial begin
        test_comb();
        test_reset();
        test_basic();
        test_clr();
        test_sat();
        test_toggle();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/and_gate.md
AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter: CNT_W, default 16, width of the statistics counters (legal range 4..32).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for all registered state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: X  input  1  first AND operand.
REQ-006 Port: Y  input  1  second AND operand.
REQ-007 Port: clr  input  1  synchronous clear of statistics counters, active-high.
REQ-008 Port: F  output  1  combinational X AND Y.
REQ-009 Port: F_q  output  1  F registered on clk.
REQ-010 Port: f_rise  output  1  one-cycle pulse when F_q goes 0->1.
REQ-011 Port: hi_cnt  output  CNT_W  count of clk edges sampling F=1, saturating.
REQ-012 Port: rise_cnt  output  CNT_W  count of f_rise pulses, saturating.

Function
REQ-013 F SHALL equal X & Y combinationally: zero latency, no dependence on clk or rst_n (including during reset).
REQ-014 F truth table SHALL be 00->0, 01->0, 10->0, 11->1; any X/Z operand SHALL give F=0 when the other operand is 0.
REQ-015 F_q SHALL capture F on every rising clk edge (1-cycle latency).
REQ-016 f_rise SHALL be registered: 1 in the cycle after F_q changes 0->1, else 0; it SHALL never stay high for two consecutive cycles.
REQ-017 hi_cnt SHALL increment by 1 on each edge where F=1 and SHALL hold at 2^CNT_W-1 (no wrap).
REQ-018 rise_cnt SHALL increment by 1 on each edge where f_rise is set and SHALL saturate at 2^CNT_W-1.
REQ-019 clr=1 SHALL zero hi_cnt and rise_cnt on the next edge; clr SHALL win over a simultaneous increment; clr SHALL NOT affect F, F_q or f_rise.

Reset
REQ-020 While rst_n=0: F_q=0, f_rise=0, hi_cnt=0, rise_cnt=0, applied immediately with no clock.
REQ-021 Reset deassertion SHALL be synchronised internally (2-flop release); first count occurs no earlier than the second edge after release.
REQ-022 Reset mid-operation SHALL discard all registered state; an F already high at release SHALL produce f_rise exactly once.

Configuration
REQ-023 Macro AND_GATE_STATS_EN: when defined, hi_cnt, rise_cnt and clr logic are built as in REQ-017..019.
REQ-024 Without AND_GATE_STATS_EN: hi_cnt and rise_cnt SHALL be tied to 0, clr ignored, ports retained; F, F_q, f_rise unchanged.

Structure
REQ-025 Package and_gate_pkg SHALL hold CNT_W_DEFAULT (16) and the saturation max-value function.
REQ-026 Sub-module and_gate_sat_cnt (CNT_W-wide saturating counter with inc and clr inputs) SHALL be instantiated twice.

Verification
REQ-027 No clock, X/Y = 00,01,10,11 each held 10 ns -> F = 0,0,0,1 sampled at end of each step.
REQ-028 rst_n=0, X=Y=1 -> F=1 immediately, F_q=0, counters 0.
REQ-029 Release reset, X=Y=1 for 5 edges -> F_q=1 after one edge, f_rise single pulse, rise_cnt=1, hi_cnt=5 (stats enabled).
REQ-030 CNT_W=4, X=Y=1 for 20 edges -> hi_cnt stops at 15.
REQ-031 clr=1 on same edge as F=1 -> hi_cnt=0 afterwards, F_q still 1.
REQ-032 Build without AND_GATE_STATS_EN, toggle X with Y=1 -> hi_cnt=rise_cnt=0, f_rise pulses per rising F.
